// File: rtl/rstseq_pkg.sv
// Shared definitions for the reset/set release sequencer.
//   - state_e      : sequencer FSM states
//   - rstseq_cnt_w : width of a counter that must hold values 0..maxval
//   - rstseq_params_ok : legality of the sequencer parameter set
package rstseq_pkg;

    typedef enum logic [2:0] {
        HOLD = 3'd0,  // global reset asserted or still synchronizing
        REL  = 3'd1,  // staggered per-bank release in progress
        DONE = 3'd2,  // all banks released, idle
        SET  = 3'd3,  // SETN pulse on latched banks
        ACK  = 3'd4   // waiting for set_req to drop
    } state_e;

    // Width needed to hold 0..maxval inclusive.
    function automatic int rstseq_cnt_w(input int maxval);
        return $clog2(maxval + 1);
    endfunction

    function automatic bit rstseq_params_ok(input int num_out, input int sync_stages,
                                            input int gap_cycles, input int set_pulse);
        return (num_out >= 1) && (num_out <= 16) && (sync_stages >= 2) &&
               (gap_cycles >= 1) && (set_pulse >= 1);
    endfunction

endpackage

// File: rtl/rst_set_release_sequencer_if.sv
// Set-request handshake between a controller (master) and the sequencer (slave).
//   set_req  : four-phase request level
//   set_mask : banks to pulse, sampled together with set_req
//   set_ack  : acknowledge level
interface rst_set_release_sequencer_if #(
    parameter int NUM_OUT = 4
);
    logic               set_req;
    logic [NUM_OUT-1:0] set_mask;
    logic               set_ack;

    modport master (output set_req, output set_mask, input set_ack);
    modport slave  (input set_req, input set_mask, output set_ack);
endinterface

// File: rtl/rstseq_sync.sv
// Async-assert, sync-deassert reset synchronizer.
//   CLK      : clock, rising edge
//   RN       : asynchronous active-low reset in
//   sync_out : goes 1 on the STAGES-th rising edge after RN rises; 0 at once when RN falls
module rstseq_sync #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic RN,
    output logic sync_out
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign chain_d[gi] = 1'b1;
            end else begin : g_rest
                assign chain_d[gi] = chain_q[gi-1];
            end

            always_ff @(posedge CLK or negedge RN) begin
                if (!RN) chain_q[gi] <= 1'b0;
                else     chain_q[gi] <= chain_d[gi];
            end
        end
    endgenerate

    assign sync_out = chain_q[STAGES-1];

endmodule

// File: rtl/rst_set_release_sequencer.sv
// Drives RN/SETN pins for NUM_OUT banks of set/reset flops.
// Reset is asserted to every bank asynchronously and released one bank at a
// time, GAP_CYCLES apart; afterwards a four-phase handshake pulses SETN low on
// the requested banks for SET_PULSE cycles. SETN is only driven while the bank
// is released, so a bank never sees RN and SETN asserted together.
//   CLK, RN   : clock and asynchronous active-low reset
//   set_if    : slave side of the set_req/set_mask/set_ack handshake
//   rn_out    : per-bank RN (active-low)
//   setn_out  : per-bank SETN (active-low)
//   seq_done  : all banks released, block idle (stays 1 during SET/ACK)
//   stage_idx : number of released banks, present only with RSTSEQ_STAGE_OUT_EN
// set_if must be instantiated with the same NUM_OUT.
module rst_set_release_sequencer
    import rstseq_pkg::*;
#(
    parameter int NUM_OUT     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int GAP_CYCLES  = 8,
    parameter int SET_PULSE   = 4
) (
    input  logic                              CLK,
    input  logic                              RN,
    rst_set_release_sequencer_if.slave        set_if,
    output logic [NUM_OUT-1:0]                rn_out,
    output logic [NUM_OUT-1:0]                setn_out,
`ifdef RSTSEQ_STAGE_OUT_EN
    output logic [rstseq_cnt_w(NUM_OUT)-1:0]  stage_idx,
`endif
    output logic                              seq_done
);

    localparam int GAP_W   = rstseq_cnt_w(GAP_CYCLES);
    localparam int PULSE_W = rstseq_cnt_w(SET_PULSE);
    localparam int REL_W   = rstseq_cnt_w(NUM_OUT);

    if (!rstseq_params_ok(NUM_OUT, SYNC_STAGES, GAP_CYCLES, SET_PULSE)) begin : g_bad_params
        $error("rst_set_release_sequencer: illegal parameter set");
    end

    logic sync_rel;

    rstseq_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .CLK      (CLK),
        .RN       (RN),
        .sync_out (sync_rel)
    );

    state_e               state_q,    state_d;
    logic [GAP_W-1:0]     gap_cnt_q,  gap_cnt_d;
    logic [PULSE_W-1:0]   pulse_cnt_q, pulse_cnt_d;
    logic [REL_W-1:0]     rel_cnt_q,  rel_cnt_d;
    logic [NUM_OUT-1:0]   mask_q,     mask_d;
    logic [NUM_OUT-1:0]   rn_q,       rn_d;
    logic [NUM_OUT-1:0]   setn_q,     setn_d;
    logic                 ack_q,      ack_d;
    logic                 done_q,     done_d;

    always_comb begin
        state_d     = state_q;
        gap_cnt_d   = gap_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        rel_cnt_d   = rel_cnt_q;
        mask_d      = mask_q;
        rn_d        = rn_q;
        setn_d      = setn_q;
        ack_d       = ack_q;
        done_d      = done_q;

        unique case (state_q)
            HOLD: begin
                // Bank 0 is released on the same edge the synchronizer output is seen.
                if (sync_rel) begin
                    state_d   = REL;
                    rn_d[0]   = 1'b1;
                    rel_cnt_d = REL_W'(1);
                    gap_cnt_d = '0;
                end
            end
            REL: begin
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    gap_cnt_d = '0;
                    if (rel_cnt_q == REL_W'(NUM_OUT)) begin
                        // Last bank has had its full gap; sequence complete.
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        for (int i = 0; i < NUM_OUT; i++) begin
                            if (i == int'(rel_cnt_q)) rn_d[i] = 1'b1;
                        end
                        rel_cnt_d = rel_cnt_q + REL_W'(1);
                    end
                end else if (gap_cnt_q != GAP_W'(GAP_CYCLES)) begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            DONE: begin
                if (set_if.set_req) begin
                    state_d     = SET;
                    mask_d      = set_if.set_mask;
                    pulse_cnt_d = '0;
                end
            end
            SET: begin
                // An empty mask skips the pulse and acknowledges one edge after the request.
                if (mask_q == '0 || pulse_cnt_q == PULSE_W'(SET_PULSE)) begin
                    state_d = ACK;
                    setn_d  = '1;
                    ack_d   = 1'b1;
                end else begin
                    setn_d      = ~mask_q;
                    pulse_cnt_d = pulse_cnt_q + PULSE_W'(1);
                end
            end
            ACK: begin
                if (!set_if.set_req) begin
                    state_d = DONE;
                    ack_d   = 1'b0;
                end
            end
            default: state_d = HOLD;
        endcase
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q     <= HOLD;
            gap_cnt_q   <= '0;
            pulse_cnt_q <= '0;
            rel_cnt_q   <= '0;
            mask_q      <= '0;
            rn_q        <= '0;
            setn_q      <= '1;
            ack_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            rel_cnt_q   <= rel_cnt_d;
            mask_q      <= mask_d;
            rn_q        <= rn_d;
            setn_q      <= setn_d;
            ack_q       <= ack_d;
            done_q      <= done_d;
        end
    end

    assign rn_out         = rn_q;
    assign setn_out       = setn_q;
    assign set_if.set_ack = ack_q;
    assign seq_done       = done_q;
`ifdef RSTSEQ_STAGE_OUT_EN
    assign stage_idx      = rel_cnt_q;
`endif

endmodule

// File: tb/tb_rst_set_release_sequencer.sv
// Directed bench for rst_set_release_sequencer at default parameters.
// Build with +define+RSTSEQ_STAGE_OUT_EN to also check stage_idx.
module tb_rst_set_release_sequencer;

    logic       CLK;
    logic       RN;
    logic [3:0] rn_out;
    logic [3:0] setn_out;
    logic       seq_done;
`ifdef RSTSEQ_STAGE_OUT_EN
    logic [2:0] stage_idx;
`endif

    int checks;
    int errors;

    rst_set_release_sequencer_if #(.NUM_OUT(4)) sif ();

    rst_set_release_sequencer #(
        .NUM_OUT(4), .SYNC_STAGES(2), .GAP_CYCLES(8), .SET_PULSE(4)
    ) dut (
        .CLK      (CLK),
        .RN       (RN),
        .set_if   (sif),
        .rn_out   (rn_out),
        .setn_out (setn_out),
`ifdef RSTSEQ_STAGE_OUT_EN
        .stage_idx(stage_idx),
`endif
        .seq_done (seq_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Bank never held in reset while its SETN is active; stage_idx tracks released banks.
    always @(negedge CLK) begin
        chk("invariant", {28'd0, ~rn_out & ~setn_out}, 32'd0);
`ifdef RSTSEQ_STAGE_OUT_EN
        chk("stage_idx", {29'd0, stage_idx}, $countones(rn_out));
`endif
    end

    // Releases RN now and checks every edge up to DONE.
    // With hold_req, set_req (mask 0011) is raised after edge 5 and must be
    // ignored until DONE: k = 36, pulse on 37..40, ack on 41.
    task automatic run_release(input bit hold_req);
        logic [3:0] exp_rn;
        RN = 1'b1;
        for (int e = 1; e <= 35; e++) begin
            tick();
            for (int i = 0; i < 4; i++) exp_rn[i] = (e >= 3 + 8 * i);
            chk($sformatf("rel_rn_e%0d", e), {28'd0, rn_out}, {28'd0, exp_rn});
            chk($sformatf("rel_done_e%0d", e), {31'd0, seq_done}, {31'd0, (e >= 35)});
            chk($sformatf("rel_setn_e%0d", e), {28'd0, setn_out}, 32'hF);
            chk($sformatf("rel_ack_e%0d", e), {31'd0, sif.set_ack}, 32'd0);
            if (hold_req && e == 5) begin
                sif.set_req  = 1'b1;
                sif.set_mask = 4'b0011;
            end
        end
        if (hold_req) begin
            tick();
            chk("early_k_setn", {28'd0, setn_out}, 32'hF);
            for (int p = 1; p <= 4; p++) begin
                tick();
                chk($sformatf("early_pulse%0d", p), {28'd0, setn_out}, 32'hC);
                chk($sformatf("early_noack%0d", p), {31'd0, sif.set_ack}, 32'd0);
            end
            tick();
            chk("early_end_setn", {28'd0, setn_out}, 32'hF);
            chk("early_ack", {31'd0, sif.set_ack}, 32'd1);
            sif.set_req = 1'b0;
            tick();
            chk("early_ack_drop", {31'd0, sif.set_ack}, 32'd0);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        RN           = 1'b0;
        sif.set_req  = 1'b0;
        sif.set_mask = 4'b0000;

        // Reset state
        repeat (3) tick();
        chk("rst_rn", {28'd0, rn_out}, 32'h0);
        chk("rst_setn", {28'd0, setn_out}, 32'hF);
        chk("rst_ack", {31'd0, sif.set_ack}, 32'd0);
        chk("rst_done", {31'd0, seq_done}, 32'd0);

        // Scenario 1: staggered release
        run_release(1'b0);

        // Scenario 2: pulse mask 0101
        sif.set_req  = 1'b1;
        sif.set_mask = 4'b0101;
        tick();
        chk("s2_k_setn", {28'd0, setn_out}, 32'hF);
        chk("s2_k_ack", {31'd0, sif.set_ack}, 32'd0);
        sif.set_mask = 4'b1111;  // changes after latch must not matter
        for (int p = 1; p <= 4; p++) begin
            tick();
            chk($sformatf("s2_pulse%0d", p), {28'd0, setn_out}, 32'hA);
            chk($sformatf("s2_noack%0d", p), {31'd0, sif.set_ack}, 32'd0);
            chk($sformatf("s2_done%0d", p), {31'd0, seq_done}, 32'd1);
        end
        tick();
        chk("s2_end_setn", {28'd0, setn_out}, 32'hF);
        chk("s2_ack", {31'd0, sif.set_ack}, 32'd1);
        tick();
        chk("s2_ack_hold", {31'd0, sif.set_ack}, 32'd1);
        chk("s2_setn_hold", {28'd0, setn_out}, 32'hF);
        sif.set_req = 1'b0;
        tick();
        chk("s2_ack_drop", {31'd0, sif.set_ack}, 32'd0);
        chk("s2_done_after", {31'd0, seq_done}, 32'd1);
        tick();

        // Scenario 3: zero mask
        sif.set_req  = 1'b1;
        sif.set_mask = 4'b0000;
        tick();
        chk("s3_k_ack", {31'd0, sif.set_ack}, 32'd0);
        tick();
        chk("s3_ack", {31'd0, sif.set_ack}, 32'd1);
        chk("s3_setn", {28'd0, setn_out}, 32'hF);
        sif.set_req = 1'b0;
        tick();
        chk("s3_ack_drop", {31'd0, sif.set_ack}, 32'd0);
        tick();

        // Scenario 5: abort mid-pulse, then re-release (with scenario 4 request)
        sif.set_req  = 1'b1;
        sif.set_mask = 4'b1111;
        tick();
        tick();
        tick();
        chk("s5_pulse", {28'd0, setn_out}, 32'h0);
        #2 RN = 1'b0;
        #1;
        chk("s5_abort_rn", {28'd0, rn_out}, 32'h0);
        chk("s5_abort_setn", {28'd0, setn_out}, 32'hF);
        chk("s5_abort_ack", {31'd0, sif.set_ack}, 32'd0);
        chk("s5_abort_done", {31'd0, seq_done}, 32'd0);
        sif.set_req = 1'b0;
        repeat (3) tick();
        chk("s5_held_rn", {28'd0, rn_out}, 32'h0);
        run_release(1'b1);

        // Scenario 6: random req/mask/RN storm; invariant checked every cycle
        for (int c = 0; c < 600; c++) begin
            int r;
            tick();
            r = int'($urandom_range(0, 59));
            if (RN && r == 0) RN = 1'b0;
            else if (!RN && r < 10) RN = 1'b1;
            sif.set_req  = ($urandom_range(0, 3) != 0);
            sif.set_mask = 4'($urandom_range(0, 15));
        end
        RN = 1'b0;
        #1;
        chk("storm_end_rn", {28'd0, rn_out}, 32'h0);
        chk("storm_end_setn", {28'd0, setn_out}, 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rst_set_release_sequencer.md
Name: rst_set_release_sequencer

Overview:
- Generates the asynchronous control pins (RN, SETN) for banks of set/reset flops in the gf180mcu 9-track library.
- Global reset is asserted asynchronously to all banks and released synchronously, one bank at a time.
- A four-phase req/ack handshake lets a controller pulse SETN on selected banks.
- Guarantees SETN and RN are never both asserted on any bank.

Parameters:
- NUM_OUT, 4, number of controlled flop banks (1..16)
- SYNC_STAGES, 2, reset-release synchronizer depth (≥2)
- GAP_CYCLES, 8, CLK cycles between successive bank releases (≥1)
- SET_PULSE, 4, SETN low-pulse width in CLK cycles (≥1)

Ports:
- CLK  input  1  clock, rising edge
- RN  input  1  reset; one clock; asynchronous, active-low
- set_req  input  1  set request, four-phase level handshake
- set_mask  input  NUM_OUT  banks to pulse; sampled with set_req
- set_ack  output  1  set acknowledge
- rn_out  output  NUM_OUT  per-bank RN, active-low
- setn_out  output  NUM_OUT  per-bank SETN, active-low
- seq_done  output  1  all banks released, block idle

Behaviour:
- Reset (RN low) takes effect immediately and asynchronously:
  - rn_out = 0, setn_out = all 1, set_ack = 0, seq_done = 0.
  - FSM goes to HOLD; synchronizer and counters clear.
- Release: RN rising feeds a SYNC_STAGES flop chain.
- FSM states and transitions:
  - HOLD -> REL when the synchronizer output is 1.
  - REL releases rn_out[0] on rising edge SYNC_STAGES+1 after RN rises.
  - rn_out[i] rises exactly GAP_CYCLES edges after rn_out[i-1].
  - REL -> DONE GAP_CYCLES edges after rn_out[NUM_OUT-1] rises; seq_done goes to 1 on that edge.
  - DONE -> SET when set_req = 1 is sampled at edge k. set_mask is latched at edge k.
  - SET drives setn_out[i] = 0 for each latched mask bit, from edge k+1 through edge k+SET_PULSE; they return to 1 at edge k+SET_PULSE+1.
  - SET -> ACK at edge k+SET_PULSE+1; set_ack = 1 on that edge.
  - ACK -> DONE on the first edge where set_req = 0 is sampled; set_ack = 0 on that edge.
- Zero mask: no pulse is generated; set_ack rises at edge k+1.
- set_req before DONE is ignored (not queued). It is honoured once in DONE if still high.
- set_mask changes after latch have no effect.
- seq_done stays 1 in SET and ACK.
- RN low in any state (mid-release, mid-pulse, mid-ack) aborts immediately. All outputs go to their reset values, including any active setn_out, which returns to 1.
- Invariant: setn_out[i] = 0 only when rn_out[i] = 1 (SET is reachable only from DONE).
- All outputs are registered; no combinational path from inputs to outputs.
- Gap counter width is clog2(GAP_CYCLES+1); pulse counter width is clog2(SET_PULSE+1). Both saturate and never wrap.

Optional Feature:
- Macro: RSTSEQ_STAGE_OUT_EN.
- Defined: adds output stage_idx (width clog2(NUM_OUT+1)) giving the number of banks currently released.
  - 0 in reset; increments on the same edge as each rn_out rise; equals NUM_OUT in DONE, SET and ACK.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package rstseq_pkg:
  - FSM state enum: HOLD, REL, DONE, SET, ACK.
  - Counter-width localparam functions.
  - Parameter legality checks.
- One natural sub-module: rstseq_sync. It is a SYNC_STAGES-deep async-assert, sync-deassert synchronizer (clocked on CLK, cleared by RN) and is reusable elsewhere.

Test Plan (defaults: NUM_OUT=4, SYNC=2, GAP=8, PULSE=4):
1. Release RN at t0 -> rn_out[0..3] rise at edges 3, 11, 19, 27; seq_done = 1 at edge 35; setn_out stays 4'hF.
2. In DONE, set_req = 1 and set_mask = 4'b0101 sampled at edge k -> setn_out = 4'b1010 for edges k+1..k+4; 4'hF at k+5; set_ack = 1 at k+5. Drop set_req -> set_ack = 0 one edge later.
3. set_mask = 0 -> set_ack at k+1; setn_out never leaves 4'hF.
4. set_req held high from edge 5 -> no setn activity before seq_done; pulse starts the edge after DONE is entered.
5. RN low mid-pulse at edge k+2 -> immediately rn_out = 0, setn_out = 4'hF, set_ack = 0, seq_done = 0. Re-release replays scenario 1 timing.
6. Randomized req/mask/RN storm -> assertion that no bank ever has rn_out[i] = 0 while setn_out[i] = 0; with RSTSEQ_STAGE_OUT_EN, stage_idx always equals the popcount of rn_out.
